ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
PS/2 device-to-host receiver. Synchronises and filters the raw ps2_clk/ps2_data lines and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Each good byte is emitted as a one-cycle strobe that drives the keyboard character buffer's char_in/write pair directly. Errors are flagged and the bad byte is dropped. There is no host-to-device (transmit) path.

Parameters:
FILTER_LEN, 4, consecutive identical samples required before the filtered ps2_clk level changes
TIMEOUT_CYCLES, 50000, idle clk cycles without a filtered ps2_clk edge before a partial frame is abandoned (1 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset
ps2_clk  in  1  raw PS/2 clock, asynchronous, idle high
ps2_data  in  1  raw PS/2 data, asynchronous, idle high
code  out  8  last good received byte
code_valid  out  1  one-cycle pulse; code is valid in the same cycle
parity_err  out  1  one-cycle pulse on parity failure
frame_err  out  1  one-cycle pulse on bad start, bad stop or timeout
busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state IDLE; code=0, code_valid=0, parity_err=0, frame_err=0, busy=0; sync flops and filtered clock preset to 1; bit counter, shift register and timeout counter cleared.
- Reset mid-frame abandons the partial frame. No output pulse is generated for it.
- Input path: 2-flop synchroniser on each line. ps2_clk_f toggles only after FILTER_LEN consecutive synchronised samples differ from its current value; shorter glitches are ignored.
- A falling edge of ps2_clk_f (fall) lasts one cycle. Data is sampled from synchronised ps2_data in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, clear the bit counter and go to DATA. On fall with data=1, pulse frame_err and stay in IDLE.
  - DATA: on fall, shift data into bit 7 of the shift register (right shift, LSB-first). After the 8th bit go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, evaluate the frame and go to IDLE.
- Frame evaluation, registered, one cycle after the stop-bit fall:
  - stop=0: frame_err pulse only, regardless of parity.
  - stop=1 and XOR(data[7:0], parity)=0: parity_err pulse.
  - Otherwise: code <= byte and code_valid pulse.
  - code holds its value until the next good frame. Outputs are never asserted together.
- Timeout: the counter clears on every fall and while in IDLE. In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES-1 pulses frame_err and returns to IDLE. Counter width is clog2(TIMEOUT_CYCLES).
- Back-to-back frames: a start fall arriving in the same cycle as the registered evaluation is accepted normally.
- No flow control. The downstream buffer always accepts a write.
- Bytes F0/E0 are passed through unchanged; interpreting them belongs downstream.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state localparams;
  - PS2_FRAME_BITS=11;
  - KEY_BREAK=8'hF0, KEY_EXT=8'hE0, KEY_LSHIFT=8'h12, shared with the character buffer;
  - BAT_OK=8'hAA, ACK=8'hFA.
- Sub-module ps2_sync_filter (parameter FILTER_LEN): 2-flop synchroniser, glitch filter and fall-edge pulse. Instantiated for ps2_clk. ps2_data uses the synchroniser only.

Test Plan:
- Model ps2_clk at a 60 us period with data changing on the rising edge. Send frame 0x1C with parity 0 and stop 1 -> exactly one code_valid, code=8'h1C, no error pulses, busy low afterwards.
- Send 0x1C with parity 1 -> one parity_err pulse, no code_valid, code keeps its previous value.
- Send 0x32 with stop=0 -> one frame_err pulse, no code_valid. A following good 0x32 -> code_valid with code=8'h32.
- Send 5 bits, then hold lines idle for TIMEOUT_CYCLES+10 -> frame_err pulse, busy falls. A following good 0xF0 then 0x12 -> two code_valid pulses, in order F0 then 12.
- Inject ps2_clk low glitches of FILTER_LEN-1 cycles in the middle of a 0x24 frame -> frame decodes as 0x24, no errors. A glitch of FILTER_LEN+2 cycles -> extra bit shifted, resulting in frame_err or parity_err.
- Assert rst for one cycle after 4 bits -> all outputs 0, state IDLE. A new full frame 0xAA -> code_valid with code=8'hAA.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding, frame geometry and the
// scan codes the keyboard character buffer also decodes.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] KEY_BREAK  = 8'hF0;
  localparam logic [7:0] KEY_EXT    = 8'hE0;
  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] BAT_OK     = 8'hAA;
  localparam logic [7:0] ACK        = 8'hFA;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus a run-length glitch filter for one PS/2 line.
// fall is a one-cycle pulse in the cycle the filtered level first reads low.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          meta;
  logic          sync;
  logic [CW-1:0] run_cnt;

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= 1'b1;
      sync    <= 1'b1;
      filt    <= 1'b1;
      run_cnt <= '0;
      fall    <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      fall <= 1'b0;
      if (sync == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        filt    <= sync;
        run_cnt <= '0;
        fall    <= ~sync;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters the line clock, deserialises 11-bit
// frames and emits each good byte as a one-cycle code/code_valid write.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | waiting for a start bit (data low on a fall)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the odd-parity bit
//   ST_STOP   | capturing the stop bit, then evaluating the frame
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic          clk_filt;
  logic          fall;
  logic          data_meta;
  logic          data_sync;

  state_t        state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic          parity_bit, parity_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic          tmo_hit;
  logic [7:0]    code_nx;
  logic          code_valid_nx;
  logic          parity_err_nx;
  logic          frame_err_nx;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .raw  (ps2_clk),
    .filt (clk_filt),
    .fall (fall)
  );

  // Data only needs synchronising: it is sampled mid-bit, long after it settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shift      <= shift_nx;
      parity_bit <= parity_nx;
      tmo_cnt    <= tmo_nx;
      code       <= code_nx;
      code_valid <= code_valid_nx;
      parity_err <= parity_err_nx;
      frame_err  <= frame_err_nx;
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    shift_nx      = shift;
    parity_nx     = parity_bit;
    code_nx       = code;
    code_valid_nx = 1'b0;
    parity_err_nx = 1'b0;
    frame_err_nx  = 1'b0;
    tmo_nx        = (state == ST_IDLE || fall) ? '0 : tmo_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (fall) begin
          if (!data_sync) begin
            bit_cnt_nx = '0;
            state_nx   = ST_DATA;
          end else begin
            frame_err_nx = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_nx   = {data_sync, shift[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          parity_nx = data_sync;
          state_nx  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_nx = ST_IDLE;
          // A bad stop bit trumps parity: the frame boundary itself is suspect.
          if (!data_sync) begin
            frame_err_nx = 1'b1;
          end else if (!parity_ok(shift, parity_bit)) begin
            parity_err_nx = 1'b1;
          end else begin
            code_nx       = shift;
            code_valid_nx = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (state != ST_IDLE && !fall && tmo_hit) begin
      state_nx     = ST_IDLE;
      frame_err_nx = 1'b1;
      tmo_nx       = '0;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of whole frames plus hand-built sequences
// for timeout, glitches and mid-frame reset. PS/2 clock is scaled down.
module tb_ps2_rx;

  localparam int FL   = 4;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int n_valid = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_overlap = 0;
  logic [7:0] codes[$];

  ps2_rx #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid === 1'b1) begin
        n_valid <= n_valid + 1;
        codes.push_back(code);
      end
      if (parity_err === 1'b1) n_perr <= n_perr + 1;
      if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
      if (int'(code_valid) + int'(parity_err) + int'(frame_err) > 1) n_overlap <= n_overlap + 1;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    int         exp_valid;
    int         exp_perr;
    int         exp_ferr;
    logic [7:0] exp_code;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] data, input logic bad_par, input logic stop);
    logic par;
    par = ~(^data) ^ bad_par;
    return {stop, par, data, 1'b0};
  endfunction

  // Send the first nbits of a frame; bits in gmask get a ps2_clk low glitch
  // of glen cycles while the line clock is high.
  task automatic send_bits(input logic [10:0] bits, input int nbits,
                           input logic [10:0] gmask, input int glen);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (gmask[i]) begin
        wait_cyc(4);
        ps2_clk = 1'b0;
        wait_cyc(glen);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 4 - glen);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] bits);
    send_bits(bits, 11, 11'b0, 0);
    wait_cyc(40);
  endtask

  vec_t vecs[4];
  int   v0, p0, f0, q0;

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C};
    vecs[2] = '{8'h32, 1'b0, 1'b0, 0, 0, 1, 8'h1C};
    vecs[3] = '{8'h32, 1'b0, 1'b1, 1, 0, 0, 8'h32};

    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    check("reset code", code, 8'h00);
    check("reset code_valid", code_valid, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);

    for (int i = 0; i < 4; i++) begin
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      send_frame(frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop));
      check($sformatf("vec%0d valid pulses", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d parity_err pulses", i), n_perr - p0, vecs[i].exp_perr);
      check($sformatf("vec%0d frame_err pulses", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d code", i), code, vecs[i].exp_code);
      check($sformatf("vec%0d busy", i), busy, 1'b0);
    end

    // Partial frame then silence: must be abandoned by the timeout.
    v0 = n_valid; f0 = n_ferr;
    send_bits(frame(8'h55, 1'b0, 1'b1), 5, 11'b0, 0);
    check("timeout busy mid-frame", busy, 1'b1);
    wait_cyc(TMO + 10);
    check("timeout frame_err", n_ferr - f0, 1);
    check("timeout valid", n_valid - v0, 0);
    check("timeout busy after", busy, 1'b0);

    v0 = n_valid; q0 = codes.size();
    send_frame(frame(8'hF0, 1'b0, 1'b1));
    send_frame(frame(8'h12, 1'b0, 1'b1));
    check("F0/12 valid pulses", n_valid - v0, 2);
    if (codes.size() >= q0 + 2) begin
      check("F0/12 first code", codes[q0], 8'hF0);
      check("F0/12 second code", codes[q0 + 1], 8'h12);
    end else begin
      check("F0/12 code count", codes.size() - q0, 2);
    end

    // Short glitches on several high phases are filtered out.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_bits(frame(8'h24, 1'b0, 1'b1), 11, 11'b00101010100, FL - 1);
    wait_cyc(40);
    check("short glitch valid", n_valid - v0, 1);
    check("short glitch code", code, 8'h24);
    check("short glitch errors", (n_perr - p0) + (n_ferr - f0), 0);

    // Long glitch on d0 (a zero) duplicates it: parity fails, then the real
    // stop bit arrives in IDLE as a bad start.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_bits(frame(8'h24, 1'b0, 1'b1), 11, 11'b00000000010, FL + 2);
    wait_cyc(40);
    check("long glitch valid", n_valid - v0, 0);
    check("long glitch parity_err", n_perr - p0, 1);
    check("long glitch frame_err", n_ferr - f0, 1);
    check("long glitch code held", code, 8'h24);

    // Reset mid-frame: partial frame vanishes silently.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_bits(frame(8'h6B, 1'b0, 1'b1), 4, 11'b0, 0);
    check("pre-reset busy", busy, 1'b1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(1);
    check("mid reset code", code, 8'h00);
    check("mid reset busy", busy, 1'b0);
    check("mid reset pulses", {code_valid, parity_err, frame_err}, 3'b000);
    wait_cyc(TMO + 10);
    check("post reset no pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
    send_frame(frame(8'hAA, 1'b0, 1'b1));
    check("post reset valid", n_valid - v0, 1);
    check("post reset code", code, 8'hAA);

    check("no overlapping pulses", n_overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
